// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequences a run of operand bytes into a wide signed accumulator.
// Each accepted byte is added or subtracted, and a sticky signed-overflow flag is
// kept. The final sum is presented on a held valid/ready output handshake.
module add_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int ACC_W = WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] op_count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] remaining;

  logic [ACC_W-1:0] operand;
  logic [ACC_W-1:0] next_acc;
  logic             step_ovf;
  logic             beat;

  assign operand = {{(ACC_W-WIDTH){1'b0}}, in_data};
  assign beat    = in_valid && (state == LOAD);

  // Next accumulator value and overflow detection; the operand is always non-negative.
  always_comb begin
    next_acc = acc;
    step_ovf = 1'b0;
    if (in_sub) begin
      next_acc = acc - operand;
      step_ovf = acc[ACC_W-1] & ~next_acc[ACC_W-1];
    end else begin
      next_acc = acc + operand;
      step_ovf = ~acc[ACC_W-1] & next_acc[ACC_W-1];
    end
  end

  // Run sequencing: state, accumulator, sticky overflow and remaining-operand count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= op_count;
            state     <= (op_count != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (beat) begin
            acc       <= next_acc;
            ovf       <= ovf | step_ovf;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: scenario tasks drive runs into add_seq_ctrl; expected results
// from an integer-range reference model are queued and compared on the output handshake.
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sub;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ovf;
  logic        out_ready;
  logic        busy;

  typedef struct {
    logic [11:0] data;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] m_acc;
  logic        m_ovf;
  int          m_rem;
  int          checks;
  int          errors;
  int          cyc;
  int          start_cyc;

  add_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_count  (op_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Free-running clock and a cycle counter for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference step: true signed arithmetic, overflow when outside the 12-bit range.
  task automatic model_beat(input logic [7:0] d, input logic s);
    int a;
    int v;
    a = $signed(m_acc);
    v = s ? (a - int'(d)) : (a + int'(d));
    if (v > 2047 || v < -2048) m_ovf = 1'b1;
    m_acc = v[11:0];
    m_rem = m_rem - 1;
    if (m_rem == 0) sb.push_back('{data: m_acc, ovf: m_ovf});
  endtask

  // Called at a negedge; drives a one-cycle start and returns at the next negedge.
  task automatic do_start(input logic [3:0] n);
    start     = 1'b1;
    op_count  = n;
    start_cyc = cyc;
    m_acc     = '0;
    m_ovf     = 1'b0;
    m_rem     = int'(n);
    if (n == 4'd0) sb.push_back('{data: 12'h000, ovf: 1'b0});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for acceptance, returns at the following negedge.
  task automatic send_beat(input logic [7:0] d, input logic s);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("[TB] FAIL beat_accept: in_ready=%0b required 1", in_ready);
    end else begin
      model_beat(d, s);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, compares against the queue, holds backpressure, then handshakes.
  task automatic wait_result(input int lat, input int hold);
    int   t;
    exp_t e;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("[TB] FAIL result_timeout: out_valid=%0b required 1", out_valid);
      return;
    end
    if (lat >= 0) begin
      checks++;
      if (cyc - start_cyc !== lat) begin
        errors++;
        $display("[TB] FAIL latency: got %0d cycles required %0d", cyc - start_cyc, lat);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: size=0 required >0");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (out_data !== e.data || out_ovf !== e.ovf) begin
      errors++;
      $display("[TB] FAIL result: data=%03h ovf=%0b required data=%03h ovf=%0b",
               out_data, out_ovf, e.data, e.ovf);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_ovf !== e.ovf) begin
        errors++;
        $display("[TB] FAIL hold_stable: valid=%0b data=%03h ovf=%0b required 1/%03h/%0b",
                 out_valid, out_data, out_ovf, e.data, e.ovf);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL return_idle: valid=%0b busy=%0b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_data !== 12'h000 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: rdy=%0b val=%0b busy=%0b data=%03h ovf=%0b required 0/0/0/000/0",
               in_ready, out_valid, busy, out_data, out_ovf);
    end
    start    = 1'b1;
    op_count = 4'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_beats_start: busy=%0b required 0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    do_start(4'd3);
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    send_beat(8'd30, 1'b0);
    wait_result(4, 0);
  endtask

  task automatic test_mixed_sub();
    do_start(4'd2);
    send_beat(8'd5, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold: rdy=%0b val=%0b required 1/0", in_ready, out_valid);
      end
    end
    send_beat(8'd9, 1'b1);
    wait_result(-1, 2);
  endtask

  task automatic test_overflow();
    do_start(4'd15);
    for (int i = 1; i <= 15; i++) begin
      send_beat(8'd255, 1'b0);
      if (i == 8 || i == 9) begin
        checks++;
        if (out_ovf !== (i == 9)) begin
          errors++;
          $display("[TB] FAIL ovf_onset: beat %0d ovf=%0b required %0b", i, out_ovf, i == 9);
        end
      end
    end
    wait_result(16, 0);
  endtask

  task automatic test_zero_count();
    do_start(4'd0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_count: rdy=%0b val=%0b required 0/1", in_ready, out_valid);
    end
    wait_result(1, 0);
  endtask

  task automatic test_ignored_start_reset();
    do_start(4'd4);
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b0);
    start    = 1'b1;
    op_count = 4'd1;
    send_beat(8'd3, 1'b0);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_start: rdy=%0b val=%0b required 1/0", in_ready, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_data !== 12'h000 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: rdy=%0b val=%0b busy=%0b data=%03h ovf=%0b required 0/0/0/000/0",
               in_ready, out_valid, busy, out_data, out_ovf);
    end
    do_start(4'd1);
    send_beat(8'd7, 1'b0);
    wait_result(2, 0);
  endtask

  task automatic test_back_to_back();
    do_start(4'd2);
    send_beat(8'd100, 1'b0);
    send_beat(8'd50, 1'b1);
    wait_result(3, 1);
    do_start(4'd1);
    send_beat(8'd3, 1'b0);
    wait_result(2, 0);
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    op_count  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    start_cyc = 0;
    m_acc     = '0;
    m_ovf     = 1'b0;
    m_rem     = 0;
    @(negedge clk);
    test_reset();
    test_basic_add();
    test_mixed_sub();
    test_overflow();
    test_zero_count();
    test_ignored_start_reset();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: size=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
